exc_irq_ctrl: RTL and testbench

- Parametrised exception/interrupt controller for the single-cycle LEGv8 core.
- Replaces the single-line ExtIRQ/NotAnInstr combinational logic with NUM_IRQ maskable, prioritised external request channels and per-channel edge/level mode.
- Adds a take/service/return state machine with saved status and double-fault detection.
- Sits between the main decoder (NotAnInstr, ERet) and the datapath's exception-vector/ELR logic (ExcAck).

---
 rtl/exc_irq_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_exc_irq_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exc_irq_ctrl.sv
// -----------------------------------------------------------------------------
// exc_irq_ctrl -- exception / interrupt controller for the single-cycle LEGv8
// core.
//
// NUM_IRQ external request lines are synchronised, latched as pending
// (per-channel level or rising-edge mode), masked and priority-selected
// (channel 0 highest). An undefined opcode beats every IRQ. Once the datapath
// has vectored (ExcAck) the controller enters SERVICE. Further requests are
// held off until ERET. An undefined opcode inside the handler raises a sticky
// double fault.
//
// Ports
//   clk          clock
//   reset        synchronous, active-low reset
//   ExtIRQ       asynchronous external requests, one per channel
//   IrqMask      1 = channel may be selected
//   NotAnInstr   decoder: current opcode is invalid
//   ERet         decoder: current instruction is ERET
//   ExcAck       datapath wrote ELR/ESR this cycle
//   Exc          exception request to the datapath (combinational)
//   EStatus      cause: 0000 none, 0001 IRQ, 0010 undefined, 1111 double fault
//   IrqId        winning channel when EStatus = 0001, else 0
//   ExtlAck      one-cycle acknowledge pulse to the serviced channel
//   SavedStatus  EStatus captured at the take
//   InService    handler is active
//   DoubleFault  sticky double-fault flag
// -----------------------------------------------------------------------------
module exc_irq_ctrl #(
  parameter int                 NUM_IRQ     = 4,
  parameter int                 ID_W        = 4,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK   = '0,
  parameter int                 SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] ExtIRQ,
  input  logic [NUM_IRQ-1:0] IrqMask,
  input  logic               NotAnInstr,
  input  logic               ERet,
  input  logic               ExcAck,
  output logic               Exc,
  output logic [3:0]         EStatus,
  output logic [ID_W-1:0]    IrqId,
  output logic [NUM_IRQ-1:0] ExtlAck,
  output logic [3:0]         SavedStatus,
  output logic               InService,
  output logic               DoubleFault
);

  localparam logic [3:0] ST_NONE   = 4'b0000;
  localparam logic [3:0] ST_IRQ    = 4'b0001;
  localparam logic [3:0] ST_UNDEF  = 4'b0010;
  localparam logic [3:0] ST_DFAULT = 4'b1111;

  typedef enum logic {
    IDLE    = 1'b0,
    SERVICE = 1'b1
  } state_e;

  // Input synchroniser
  logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0] s;
  logic [NUM_IRQ-1:0] s_prev_q;

  // Pending / selection
  logic [NUM_IRQ-1:0] pend_q;
  logic [NUM_IRQ-1:0] pend_d;
  logic [NUM_IRQ-1:0] cand;
  logic [NUM_IRQ-1:0] win_onehot;
  logic [NUM_IRQ-1:0] edge_clr;
  logic [ID_W-1:0]    winner;
  logic               irq_any;
  logic               take_irq;

  // Handler state and registered outputs
  state_e             state_q;
  logic [NUM_IRQ-1:0] ext_ack_q;
  logic [3:0]         saved_q;
  logic               in_service_q;
  logic               dfault_q;

  // ---------------------------------------------------------------------------
  // Synchroniser chain. s_prev_q keeps last cycle's synchronised value for
  // rising-edge detection on edge-mode channels.
  // NOTE: the synchroniser flops are ordinary registers (not a memory), so
  // clearing them on reset is cheap and keeps a stale pre-reset edge from
  // appearing as a fresh request once reset releases.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      s_prev_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the value the
      // previous stage held before this edge, which is what forms the chain.
      sync_q[0] <= ExtIRQ;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      s_prev_q <= s;
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Priority select: the lowest set index of the masked pending vector wins.
  // Scanning downwards lets the lowest index overwrite any higher one.
  // NOTE: every variable gets a default before the loop so no path can leave
  // it unassigned, which would otherwise infer a latch.
  // ---------------------------------------------------------------------------
  always_comb begin
    cand       = pend_q & IrqMask;
    winner     = '0;
    win_onehot = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (cand[k]) begin
        winner        = ID_W'(k);
        win_onehot    = '0;
        win_onehot[k] = 1'b1;
      end
    end
  end

  assign irq_any = |cand;

  // ---------------------------------------------------------------------------
  // Exception request. Re-evaluated every cycle so that a cause that changes
  // before the ack (e.g. a dropped level line) is the one that gets taken.
  // ---------------------------------------------------------------------------
  always_comb begin
    Exc     = 1'b0;
    EStatus = ST_NONE;
    IrqId   = '0;
    if (reset) begin
      case (state_q)
        IDLE: begin
          if (NotAnInstr) begin
            Exc     = 1'b1;
            EStatus = ST_UNDEF;
          end else if (irq_any) begin
            Exc     = 1'b1;
            EStatus = ST_IRQ;
            IrqId   = winner;
          end
        end
        SERVICE: begin
          if (NotAnInstr) begin
            Exc     = 1'b1;
            EStatus = ST_DFAULT;
          end
        end
        default: ;
      endcase
    end
  end

  // An IRQ take happens when the datapath acks while an IRQ is the cause.
  assign take_irq = (state_q == IDLE) && ExcAck && (EStatus == ST_IRQ);
  assign edge_clr = take_irq ? (win_onehot & EDGE_MASK) : '0;

  // Level channels mirror the synchronised line. Edge channels latch a rising
  // edge and hold it until their own take; a new edge wins over the clear.
  assign pend_d = (EDGE_MASK  & ((s & ~s_prev_q) | (pend_q & ~edge_clr)))
                | (~EDGE_MASK & s);

  always_ff @(posedge clk) begin
    if (!reset) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  // ---------------------------------------------------------------------------
  // Take / service / return state machine with registered outputs.
  // Pending keeps accumulating in SERVICE; selection is simply not offered.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      ext_ack_q    <= '0;
      saved_q      <= ST_NONE;
      in_service_q <= 1'b0;
      dfault_q     <= 1'b0;
    end else begin
      ext_ack_q <= '0;
      case (state_q)
        IDLE: begin
          // ExcAck without a request is ignored; ERet has no meaning here.
          if (Exc && ExcAck) begin
            state_q      <= SERVICE;
            saved_q      <= EStatus;
            in_service_q <= 1'b1;
            if (EStatus == ST_IRQ) ext_ack_q <= win_onehot;
          end
        end
        SERVICE: begin
          // A fault inside the handler freezes the state; the core cannot
          // usefully return from a handler that itself faulted.
          if (NotAnInstr) begin
            dfault_q <= 1'b1;
          end else if (ERet) begin
            state_q      <= IDLE;
            in_service_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ExtlAck     = ext_ack_q;
  assign SavedStatus = saved_q;
  assign InService   = in_service_q;
  assign DoubleFault = dfault_q;

endmodule

// File: tb/tb_exc_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_exc_irq_ctrl -- self-checking bench for exc_irq_ctrl.
//
// The stimulus process drives inputs, advances a behavioural reference model
// on every clock edge and pushes the expected outputs for each cycle into a
// queue; a separate monitor pops and compares them mid-cycle. Directed
// scenarios are followed by a randomized run. A few directed spot checks pin
// absolute values from the controller's rules.
// -----------------------------------------------------------------------------
module tb_exc_irq_ctrl;

  localparam int         NI   = 4;
  localparam int         IDW  = 4;
  localparam int         SS   = 2;
  localparam logic [3:0] EDGE = 4'b1000;

  logic           clk = 1'b0;
  logic           reset;
  logic [NI-1:0]  ExtIRQ;
  logic [NI-1:0]  IrqMask;
  logic           NotAnInstr;
  logic           ERet;
  logic           ExcAck;
  logic           Exc;
  logic [3:0]     EStatus;
  logic [IDW-1:0] IrqId;
  logic [NI-1:0]  ExtlAck;
  logic [3:0]     SavedStatus;
  logic           InService;
  logic           DoubleFault;

  exc_irq_ctrl #(
    .NUM_IRQ    (NI),
    .ID_W       (IDW),
    .EDGE_MASK  (EDGE),
    .SYNC_STAGES(SS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ExtIRQ     (ExtIRQ),
    .IrqMask    (IrqMask),
    .NotAnInstr (NotAnInstr),
    .ERet       (ERet),
    .ExcAck     (ExcAck),
    .Exc        (Exc),
    .EStatus    (EStatus),
    .IrqId      (IrqId),
    .ExtlAck    (ExtlAck),
    .SavedStatus(SavedStatus),
    .InService  (InService),
    .DoubleFault(DoubleFault)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: line history, pending bits, handler flag.
  // ---------------------------------------------------------------------------
  typedef struct {
    bit       exc;
    bit [3:0] st;
    bit [3:0] id;
    bit [3:0] ack;
    bit [3:0] saved;
    bit       busy;
    bit       df;
  } exp_t;

  exp_t     exp_q[$];
  bit [3:0] hist[$];   // hist[i] = ExtIRQ sampled i+1 edges ago
  bit [3:0] m_pend;
  bit       m_busy;
  bit [3:0] m_saved;
  bit       m_df;
  bit [3:0] m_ack;
  bit       m_init = 1'b0;

  function automatic void exp_comb(output bit e, output bit [3:0] st, output bit [3:0] id);
    bit [3:0] c;
    bit [3:0] lo;
    e = 1'b0; st = 4'd0; id = 4'd0;
    if (reset !== 1'b1) return;
    if (!m_busy) begin
      c = m_pend & IrqMask;
      if (NotAnInstr) begin
        e = 1'b1; st = 4'd2;
      end else if (c != 0) begin
        lo = c & (~c + 4'd1);           // isolate lowest set bit
        e = 1'b1; st = 4'd1; id = 4'($clog2(lo));
      end
    end else if (NotAnInstr) begin
      e = 1'b1; st = 4'hF;
    end
  endfunction

  function automatic void model_edge();
    bit       e;
    bit [3:0] st, id, s, sp, np;
    bit       take;
    if (reset !== 1'b1) begin
      hist.delete();
      repeat (SS + 1) hist.push_back(4'd0);
      m_pend = 0; m_busy = 0; m_saved = 0; m_df = 0; m_ack = 0;
      m_init = 1'b1;
      return;
    end
    if (!m_init) return;
    exp_comb(e, st, id);
    take = !m_busy && e && ExcAck;
    s  = hist[SS-1];
    sp = hist[SS];
    for (int k = 0; k < NI; k++) begin
      if (EDGE[k]) np[k] = (s[k] && !sp[k]) || (m_pend[k] && !(take && st == 1 && id == k));
      else         np[k] = s[k];
    end
    m_ack = (take && st == 1) ? (4'd1 << id) : 4'd0;
    if (take) begin
      m_busy = 1; m_saved = st;
    end else if (m_busy) begin
      if (NotAnInstr) m_df = 1;
      else if (ERet)  m_busy = 0;
    end
    hist.push_front(ExtIRQ);
    void'(hist.pop_back());
    m_pend = np;
  endfunction

  // One clock: publish this cycle's expectation, then advance the model.
  task automatic step(input int n = 1);
    exp_t x;
    repeat (n) begin
      @(negedge clk);
      if (m_init) begin
        exp_comb(x.exc, x.st, x.id);
        x.ack = m_ack; x.saved = m_saved; x.busy = m_busy; x.df = m_df;
        exp_q.push_back(x);
      end
      @(posedge clk);
      model_edge();
      #1;
    end
  endtask

  // Monitor: compares whatever the DUT presents against the queued result.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("Exc",         32'(Exc),         32'(x.exc));
        check("EStatus",     32'(EStatus),     32'(x.st));
        check("IrqId",       32'(IrqId),       32'(x.id));
        check("ExtlAck",     32'(ExtlAck),     32'(x.ack));
        check("SavedStatus", 32'(SavedStatus), 32'(x.saved));
        check("InService",   32'(InService),   32'(x.busy));
        check("DoubleFault", 32'(DoubleFault), 32'(x.df));
      end
    end
  end

  initial begin
    reset = 1'b0; ExtIRQ = '0; IrqMask = '0;
    NotAnInstr = 1'b0; ERet = 1'b0; ExcAck = 1'b0;
    step(2);

    // 1: level IRQ on channel 2, latency and take.
    reset = 1'b1; IrqMask = 4'hF; ExtIRQ = 4'b0100;
    #1 check("s1_idle_exc", 32'(Exc), 0);
    step(3);
    #1 check("s1_exc", 32'(Exc), 1);
    check("s1_status", 32'(EStatus), 1);
    check("s1_id", 32'(IrqId), 2);
    ExcAck = 1'b1; step(); ExcAck = 1'b0;
    #1 check("s1_ack", 32'(ExtlAck), 4'b0100);
    check("s1_insvc", 32'(InService), 1);
    check("s1_saved", 32'(SavedStatus), 1);
    check("s1_exc_svc", 32'(Exc), 0);
    step();
    #1 check("s1_ack_pulse", 32'(ExtlAck), 0);

    // 2: undefined opcode beats IRQs; then lowest channel wins.
    ExtIRQ = '0; ERet = 1'b1; step(); ERet = 1'b0;
    step(3);
    ExtIRQ = 4'b1010; NotAnInstr = 1'b1;
    step(3);
    #1 check("s2_status", 32'(EStatus), 2);
    check("s2_id", 32'(IrqId), 0);
    ExcAck = 1'b1; step(); ExcAck = 1'b0; NotAnInstr = 1'b0;
    #1 check("s2_saved", 32'(SavedStatus), 2);
    check("s2_noack", 32'(ExtlAck), 0);
    ERet = 1'b1; step(); ERet = 1'b0;
    #1 check("s2_ret_exc", 32'(Exc), 1);
    check("s2_ret_id", 32'(IrqId), 1);
    ExcAck = 1'b1; step(); ExcAck = 1'b0;
    #1 check("s2_ack1", 32'(ExtlAck), 4'b0010);
    ExtIRQ = '0; ERet = 1'b1; step(); ERet = 1'b0;
    step(3);
    #1 check("s2_edge3_id", 32'(IrqId), 3);
    ExcAck = 1'b1; step(); ExcAck = 1'b0;
    ERet = 1'b1; step(); ERet = 1'b0;
    step(3);

    // 3: masked edge pulse is remembered until unmasked, taken exactly once.
    IrqMask = 4'b0111; ExtIRQ = 4'b1000; step(); ExtIRQ = '0;
    step(20);
    #1 check("s3_masked", 32'(Exc), 0);
    IrqMask = 4'hF;
    #1 check("s3_unmask_exc", 32'(Exc), 1);
    check("s3_unmask_id", 32'(IrqId), 3);
    ExcAck = 1'b1; step(); ExcAck = 1'b0;
    #1 check("s3_ack", 32'(ExtlAck), 4'b1000);
    ERet = 1'b1; step(); ERet = 1'b0;
    step(3);
    #1 check("s3_no_retake", 32'(Exc), 0);

    // 4: no nesting while in service; request surfaces after return.
    NotAnInstr = 1'b1; ExcAck = 1'b1; step(); NotAnInstr = 1'b0; ExcAck = 1'b0;
    ExtIRQ = 4'b0001; step(4);
    #1 check("s4_nonest", 32'(Exc), 0);
    check("s4_insvc", 32'(InService), 1);
    ERet = 1'b1; step(); ERet = 1'b0;
    #1 check("s4_ret_exc", 32'(Exc), 1);
    check("s4_ret_id", 32'(IrqId), 0);
    ExcAck = 1'b1; step(); ExcAck = 1'b0; ExtIRQ = '0;
    #1 check("s4_ack", 32'(ExtlAck), 4'b0001);

    // 5: double fault, then reset mid-handler.
    NotAnInstr = 1'b1;
    #1 check("s5_exc", 32'(Exc), 1);
    check("s5_status", 32'(EStatus), 4'hF);
    step();
    #1 check("s5_df", 32'(DoubleFault), 1);
    check("s5_insvc", 32'(InService), 1);
    reset = 1'b0;
    #1 check("s5_rst_exc", 32'(Exc), 0);
    step(); NotAnInstr = 1'b0;
    #1 check("s5_rst_insvc", 32'(InService), 0);
    check("s5_rst_df", 32'(DoubleFault), 0);
    check("s5_rst_saved", 32'(SavedStatus), 0);
    reset = 1'b1;

    // 6: stray ExcAck and ERet in IDLE do nothing.
    ExcAck = 1'b1; step(); ExcAck = 1'b0;
    ERet = 1'b1; step(); ERet = 1'b0;
    #1 check("s6_insvc", 32'(InService), 0);
    check("s6_ack", 32'(ExtlAck), 0);

    // Randomized run against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) ExtIRQ = 4'($urandom);
      if ($urandom_range(0, 7) == 0) IrqMask = 4'($urandom);
      NotAnInstr = ($urandom_range(0, 15) == 0);
      ERet       = ($urandom_range(0, 3) == 0);
      ExcAck     = ($urandom_range(0, 2) == 0);
      reset      = ($urandom_range(0, 199) != 0);
      step();
    end

    // Bounded drain of outstanding expectations.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
